// File: rtl/montexp_ctrl_if.sv
`timescale 1ns/1ps
// Multiplier-side bus of the modular exponentiation sequencer.
// master: the sequencer (issues operands, receives the product).
// slave : the Montgomery multiplier.
interface montexp_ctrl_if #(
   parameter int NBITS = 2048
);
   localparam int MSW = $clog2(NBITS) + 3;

   logic             mul_enable_p;
   logic [NBITS-1:0] mul_a;
   logic [NBITS-1:0] mul_b;
   logic [NBITS-1:0] mul_m;
   logic [MSW-1:0]   mul_m_size;
   logic [NBITS-1:0] mul_y;
   logic             mul_done_p;

   modport master (
      output mul_enable_p, mul_a, mul_b, mul_m, mul_m_size,
      input  mul_y, mul_done_p
   );

   modport slave (
      input  mul_enable_p, mul_a, mul_b, mul_m, mul_m_size,
      output mul_y, mul_done_p
   );
endinterface

// File: rtl/montexp_ctrl.sv
`timescale 1ns/1ps
// montexp_ctrl: left-to-right square-and-multiply sequencer over one shared
// Montgomery multiplier. Operands and result are in the Montgomery domain.
// Optional feature macro: MONTEXP_FROM_MONT_EN appends one multiply-by-1 so the
// result leaves the Montgomery domain.
//
// state      | meaning
// IDLE       | waiting for start_p
// SQR_ISSUE  | issue acc*acc (one-cycle mul_enable_p)
// SQR_WAIT   | wait for square product
// MUL_ISSUE  | issue acc*base (one-cycle mul_enable_p)
// MUL_WAIT   | wait for multiply product
// NEXT       | step to next lower exponent bit or finish
// CONV_ISSUE | issue acc*1 (optional domain conversion)
// CONV_WAIT  | wait for conversion product
// DONE       | publish result, pulse done_irq_p
module montexp_ctrl #(
   parameter int NBITS = 2048,
   parameter int EBITS = 2048
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_p,
   input  logic [NBITS-1:0]           base_m,
   input  logic [NBITS-1:0]           one_m,
   input  logic [EBITS-1:0]           exp,
   input  logic [$clog2(EBITS):0]     exp_size,
   input  logic [NBITS-1:0]           m,
   input  logic [$clog2(NBITS)+2:0]   m_size,
   montexp_ctrl_if.master             mul,
   output logic [NBITS-1:0]           result,
   output logic                       busy,
   output logic                       done_irq_p
);
   localparam int ESW = $clog2(EBITS) + 1;
   localparam int IW  = $clog2(EBITS);

   typedef enum logic [3:0] {
      IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, CONV_ISSUE, CONV_WAIT, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [NBITS-1:0] acc, acc_nxt;
   logic [NBITS-1:0] base_r;
   logic [EBITS-1:0] exp_r;
   logic [IW-1:0]    idx;
   logic [ESW-1:0]   size_clamped;
   logic             issue_nxt;

   // Exponent lengths beyond EBITS are treated as EBITS.
   always_comb begin
      size_clamped = exp_size;
      if (exp_size > ESW'(EBITS)) size_clamped = ESW'(EBITS);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and accumulator update; products are only taken in WAIT states.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      case (state)
         IDLE: begin
            if (start_p) begin
               acc_nxt   = one_m;
               state_nxt = (size_clamped == '0) ? DONE : SQR_ISSUE;
            end
         end
         SQR_ISSUE: state_nxt = SQR_WAIT;
         SQR_WAIT: begin
            if (mul.mul_done_p) begin
               acc_nxt   = mul.mul_y;
               state_nxt = exp_r[idx] ? MUL_ISSUE : NEXT;
            end
         end
         MUL_ISSUE: state_nxt = MUL_WAIT;
         MUL_WAIT: begin
            if (mul.mul_done_p) begin
               acc_nxt   = mul.mul_y;
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            if (idx == '0) begin
`ifdef MONTEXP_FROM_MONT_EN
               state_nxt = CONV_ISSUE;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = SQR_ISSUE;
            end
         end
`ifdef MONTEXP_FROM_MONT_EN
         CONV_ISSUE: state_nxt = CONV_WAIT;
         CONV_WAIT: begin
            if (mul.mul_done_p) begin
               acc_nxt   = mul.mul_y;
               state_nxt = DONE;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign issue_nxt = (state_nxt == SQR_ISSUE) || (state_nxt == MUL_ISSUE) ||
                      (state_nxt == CONV_ISSUE);

   // Operand latch, accumulator, bit index and exponent bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         base_r <= '0;
         exp_r  <= '0;
         idx    <= '0;
      end else begin
         acc <= acc_nxt;
         if (state == IDLE && start_p) begin
            base_r <= base_m;
            exp_r  <= exp;
            idx    <= IW'(size_clamped - ESW'(1));
         end else if (state == NEXT && idx != '0) begin
            idx <= idx - IW'(1);
         end
      end
   end

   // Multiplier operands are loaded entering an issue state and then held,
   // so they stay stable until the product returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul.mul_enable_p <= 1'b0;
         mul.mul_a        <= '0;
         mul.mul_b        <= '0;
         mul.mul_m        <= '0;
         mul.mul_m_size   <= '0;
      end else begin
         mul.mul_enable_p <= issue_nxt;
         if (state == IDLE && start_p) begin
            mul.mul_m      <= m;
            mul.mul_m_size <= m_size;
         end
         case (state_nxt)
            SQR_ISSUE: begin
               mul.mul_a <= acc_nxt;
               mul.mul_b <= acc_nxt;
            end
            MUL_ISSUE: begin
               mul.mul_a <= acc_nxt;
               mul.mul_b <= base_r;
            end
            CONV_ISSUE: begin
               mul.mul_a <= acc_nxt;
               mul.mul_b <= {{(NBITS-1){1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end

   // Host-side status: busy from accepted start to completion, one-cycle done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         result     <= '0;
         busy       <= 1'b0;
         done_irq_p <= 1'b0;
      end else begin
         done_irq_p <= (state == DONE);
         if (state == DONE) begin
            result <= acc;
            busy   <= 1'b0;
         end else if (state == IDLE && start_p) begin
            busy <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_montexp_ctrl.sv
`timescale 1ns/1ps
// Bench for montexp_ctrl: behavioural fixed-latency Montgomery multiplier plus
// a scoreboard of expected multiplier operations and final results.
module tb_montexp_ctrl;
   localparam int NBITS = 16;
   localparam int EBITS = 8;
   localparam int MSW   = $clog2(NBITS) + 3;
   localparam int ESW   = $clog2(EBITS) + 1;
   localparam int LAT   = 5;
   localparam logic [NBITS-1:0] MOD = 16'hFFF1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_p = 1'b0;
   logic [NBITS-1:0] base_m = '0;
   logic [NBITS-1:0] one_m = '0;
   logic [EBITS-1:0] exp_in = '0;
   logic [ESW-1:0]   exp_size = '0;
   logic [NBITS-1:0] m = '0;
   logic [MSW-1:0]   m_size = '0;
   logic [NBITS-1:0] result;
   logic             busy;
   logic             done_irq_p;

   montexp_ctrl_if #(.NBITS(NBITS)) mif ();

   montexp_ctrl #(.NBITS(NBITS), .EBITS(EBITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_p    (start_p),
      .base_m     (base_m),
      .one_m      (one_m),
      .exp        (exp_in),
      .exp_size   (exp_size),
      .m          (m),
      .m_size     (m_size),
      .mul        (mif),
      .result     (result),
      .busy       (busy),
      .done_irq_p (done_irq_p)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_mul    = 0;
   int n_done   = 0;
   int t_start  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [NBITS-1:0] montmul(input logic [NBITS-1:0] a, b, mm);
      logic [63:0] t;
      t = 64'(a) * 64'(b);
      for (int i = 0; i < NBITS; i++) begin
         if (t[0]) t = t + 64'(mm);
         t = t >> 1;
      end
      if (t >= 64'(mm)) t = t - 64'(mm);
      return t[NBITS-1:0];
   endfunction

   function automatic logic [NBITS-1:0] to_mont(input logic [63:0] x);
      logic [63:0] t;
      t = (x % 64'(MOD)) << NBITS;
      return NBITS'(t % 64'(MOD));
   endfunction

   function automatic logic [63:0] modexp(input logic [63:0] b, input logic [EBITS-1:0] e, input int n);
      logic [63:0] r;
      r = 1;
      for (int i = n - 1; i >= 0; i--) begin
         r = (r * r) % 64'(MOD);
         if (e[i]) r = (r * b) % 64'(MOD);
      end
      return r;
   endfunction

   // Behavioural multiplier: product returned LAT+1 cycles after the issue cycle.
   logic [NBITS-1:0] mdl_y = '0, mdl_a = '0, mdl_b = '0;
   logic             mdl_done = 1'b0;
   logic             spur_done = 1'b0;
   int               mdl_cnt = 0;
   logic             mdl_busy;

   assign mdl_busy       = (mdl_cnt != 0) || mdl_done;
   assign mif.mul_done_p = mdl_done | spur_done;
   assign mif.mul_y      = spur_done ? 16'hDEAD : mdl_y;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      mdl_done <= 1'b0;
      if (mif.mul_enable_p) begin
         mdl_cnt <= LAT;
         mdl_a   <= mif.mul_a;
         mdl_b   <= mif.mul_b;
         mdl_y   <= montmul(mif.mul_a, mif.mul_b, mif.mul_m);
      end else if (mdl_cnt != 0) begin
         mdl_cnt <= mdl_cnt - 1;
         if (mdl_cnt == 1) mdl_done <= 1'b1;
      end
   end

   // Scoreboard state
   byte              op_q[$];
   logic [NBITS-1:0] res_q[$];
   logic [NBITS-1:0] cur_base = '0;
   logic [NBITS-1:0] exp_acc = '0;
   logic [NBITS-1:0] last_res = '0;
   byte              mon_k;

   always @(negedge clk) begin
      if (mif.mul_enable_p) begin
         n_mul++;
         check("one_outstanding", 64'(mdl_busy), 0);
         check("issue_expected", 64'(op_q.size() != 0), 1);
         check("mul_m", mif.mul_m, MOD);
         check("mul_m_size", mif.mul_m_size, NBITS);
         if (op_q.size() != 0) begin
            mon_k = op_q.pop_front();
            check("op_a", mif.mul_a, exp_acc);
            if (mon_k == "S")      check("sqr_b", mif.mul_b, exp_acc);
            else if (mon_k == "M") check("mul_b", mif.mul_b, cur_base);
            else                   check("conv_b", mif.mul_b, 1);
         end
      end
      if (mdl_done && !spur_done && busy) begin
         check("operand_stable_a", mif.mul_a, mdl_a);
         check("operand_stable_b", mif.mul_b, mdl_b);
         exp_acc = mdl_y;
      end
      if (done_irq_p) begin
         n_done++;
         check("done_expected", 64'(res_q.size() != 0), 1);
         if (res_q.size() != 0) check("result", result, res_q.pop_front());
      end
   end

   task automatic start_run(input logic [NBITS-1:0] bplain, input logic [EBITS-1:0] e, input int sz);
      int eff;
      logic [NBITS-1:0] want;
      eff = (sz > EBITS) ? EBITS : sz;
      base_m   = to_mont(64'(bplain));
      one_m    = to_mont(1);
      exp_in   = e;
      exp_size = ESW'(sz);
      m        = MOD;
      m_size   = MSW'(NBITS);
      cur_base = base_m;
      exp_acc  = one_m;
      for (int i = eff - 1; i >= 0; i--) begin
         op_q.push_back("S");
         if (e[i]) op_q.push_back("M");
      end
      want = to_mont(modexp(64'(bplain), e, eff));
`ifdef MONTEXP_FROM_MONT_EN
      if (eff > 0) begin
         op_q.push_back("C");
         want = NBITS'(modexp(64'(bplain), e, eff));
      end
`endif
      res_q.push_back(want);
      last_res = want;
      start_p  = 1'b1;
      t_start  = cyc;
      @(negedge clk);
      start_p = 1'b0;
   endtask

   function automatic int exp_lat(input int eff, input int pop);
      int l;
      l = (eff + pop) * (LAT + 2) + eff + 2;
`ifdef MONTEXP_FROM_MONT_EN
      if (eff > 0) l = l + LAT + 2;
`endif
      return l;
   endfunction

   function automatic int exp_muls(input int eff, input int pop);
      int n;
      n = eff + pop;
`ifdef MONTEXP_FROM_MONT_EN
      if (eff > 0) n = n + 1;
`endif
      return n;
   endfunction

   task automatic wait_done(input string tag, input int budget, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         if (done_irq_p) begin
            seen   = 1'b1;
            cycles = cyc - t_start;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 64'(seen), 1);
      @(negedge clk);
   endtask

   initial begin
      int c, n0, d0;
      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_result", result, 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done_irq_p), 0);
      check("rst_enable", 64'(mif.mul_enable_p), 0);
      check("rst_mul_a", mif.mul_a, 0);
      check("rst_mul_m", mif.mul_m, 0);

      // 3^11 with exp=1011
      n0 = n_mul;
      start_run(3, 8'h0B, 4);
      check("busy_after_start", 64'(busy), 1);
      wait_done("e1011", 300, c);
      check("e1011_latency", c, exp_lat(4, 3));
      check("e1011_muls", n_mul - n0, exp_muls(4, 3));

      // exp_size = 0
      n0 = n_mul;
      start_run(5, 8'hAB, 0);
      check("z_busy_c1", 64'(busy), 1);
      check("z_done_c1", 64'(done_irq_p), 0);
      @(negedge clk);
      check("z_done_c2", 64'(done_irq_p), 1);
      check("z_busy_c2", 64'(busy), 0);
      check("z_latency", cyc - t_start, 2);
      @(negedge clk);
      check("z_muls", n_mul - n0, 0);
      check("z_result_hold", result, to_mont(1));

      // Second start while busy is ignored
      n0 = n_mul;
      start_run(3, 8'h0B, 4);
      repeat (10) @(negedge clk);
      base_m = 16'h1234; exp_in = 8'hFF; exp_size = 4'd8; m = 16'h00FF;
      start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      wait_done("ign", 300, c);
      check("ign_latency", c, exp_lat(4, 3));
      check("ign_muls", n_mul - n0, exp_muls(4, 3));

      // Spurious done in IDLE
      n0 = n_mul;
      d0 = n_done;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      check("spur_idle_busy", 64'(busy), 0);
      check("spur_idle_result", result, last_res);
      check("spur_idle_muls", n_mul - n0, 0);
      check("spur_idle_done", n_done - d0, 0);

      // Spurious done in SQR_ISSUE; bits above exp_size ignored (0xF5, size 3 -> 101)
      n0 = n_mul;
      start_run(7, 8'hF5, 3);
      check("spur_in_issue", 64'(mif.mul_enable_p), 1);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      wait_done("spur", 300, c);
      check("spur_latency", c, exp_lat(3, 2));
      check("spur_muls", n_mul - n0, exp_muls(3, 2));

      // Reset during MUL_WAIT, late product ignored
      start_run(3, 8'h0B, 4);
      repeat (9) @(negedge clk);
      check("rst_mid_outstanding", 64'(mdl_busy), 1);
      d0 = n_done;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      op_q.delete();
      res_q.delete();
      check("rstm_result", result, 0);
      check("rstm_busy", 64'(busy), 0);
      check("rstm_enable", 64'(mif.mul_enable_p), 0);
      check("rstm_mul_a", mif.mul_a, 0);
      check("rstm_mul_b", mif.mul_b, 0);
      check("rstm_mul_m", mif.mul_m, 0);
      check("rstm_mul_m_size", mif.mul_m_size, 0);
      for (int i = 0; i < 20 && mdl_busy; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("rstm_late_idle", 64'(mdl_busy), 0);
      check("rstm_no_done", n_done - d0, 0);
      check("rstm_busy_late", 64'(busy), 0);
      check("rstm_state_idle", 64'(dut.state), 0);
      n0 = n_mul;
      start_run(3, 8'h01, 1);
      wait_done("after_rst", 100, c);
      check("after_rst_muls", n_mul - n0, exp_muls(1, 1));
      check("after_rst_latency", c, exp_lat(1, 1));

      // All ones, full length
      n0 = n_mul;
      start_run(5, 8'hFF, 8);
      wait_done("ones", 500, c);
      check("ones_latency", c, exp_lat(8, 8));
      check("ones_muls", n_mul - n0, exp_muls(8, 8));

      // exp_size above EBITS clamps to EBITS
      n0 = n_mul;
      start_run(2, 8'hFF, 12);
      wait_done("clamp", 500, c);
      check("clamp_latency", c, exp_lat(8, 8));
      check("clamp_muls", n_mul - n0, exp_muls(8, 8));

      check("queues_drained", 64'(op_q.size() + res_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
